// File: rtl/uart_rx_reg_ctrl_if.sv
// Bundle between the UART byte stream, the frame controller and its register/status consumers.
// The receiver side drives rx_dv/rx_byte; the controller drives everything else.
interface uart_rx_reg_ctrl_if #(
  parameter int NUM_REGS = 4
);
  logic                    rx_dv;
  logic [7:0]              rx_byte;
  logic [8*NUM_REGS-1:0]   regs;
  logic                    wr_valid;
  logic [3:0]              wr_addr;
  logic [7:0]              wr_data;
  logic                    err;
  logic [1:0]              err_code;
  logic [7:0]              err_count;
  logic                    busy;

  modport master (
    output rx_dv, rx_byte,
    input  regs, wr_valid, wr_addr, wr_data, err, err_code, err_count, busy
  );

  modport slave (
    input  rx_dv, rx_byte,
    output regs, wr_valid, wr_addr, wr_data, err, err_code, err_count, busy
  );
endinterface

// File: rtl/uart_rx_reg_ctrl.sv
// Parses SYNC/ADDR/DATA/CHK write frames from a UART byte stream into a small register file,
// flagging bad checksums, out-of-range addresses and inter-byte timeouts.
module uart_rx_reg_ctrl #(
  parameter int          NUM_REGS     = 4,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
  parameter int          TIMEOUT_CLKS = 4340
) (
  input  logic               i_Clock,
  input  logic               i_Rst_L,
  uart_rx_reg_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE,
    GET_ADDR,
    GET_DATA,
    GET_CHK
  } state_t;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CLKS - 1);

  state_t        state_reg;
  logic [7:0]    addr_reg;
  logic [7:0]    data_reg;
  logic [15:0]   tmo_reg;
  logic          busy_reg;
  logic          wr_valid_reg;
  logic [3:0]    wr_addr_reg;
  logic [7:0]    wr_data_reg;
  logic          err_reg;
  logic [1:0]    err_code_reg;
  logic [7:0]    err_count_reg;
  logic [7:0]    regs_reg [NUM_REGS];
  logic [8*NUM_REGS-1:0] regs_flat;

  logic          in_frame;
  logic          tmo_hit;
  logic          chk_dv;
  logic          chk_bad;
  logic          addr_bad;
  logic          wr_fire;
  logic          err_fire;
  logic [1:0]    err_code_next;

  assign in_frame = (state_reg != IDLE);
  // A DV on the expiry cycle takes precedence, so the timeout only fires without one.
  assign tmo_hit  = in_frame && !bus.rx_dv && (tmo_reg == TMO_LAST);
  assign chk_dv   = (state_reg == GET_CHK) && bus.rx_dv;
  assign chk_bad  = (bus.rx_byte != (addr_reg ^ data_reg));
  assign addr_bad = (addr_reg >= 8'(NUM_REGS));
  assign wr_fire  = chk_dv && !chk_bad && !addr_bad;
  assign err_fire = tmo_hit || (chk_dv && (chk_bad || addr_bad));

  always_comb begin
    err_code_next = 2'b00;
    if (tmo_hit)
      err_code_next = 2'b11;
    else if (chk_bad)
      err_code_next = 2'b01;
    else
      err_code_next = 2'b10;
  end

  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_reg     <= IDLE;
      addr_reg      <= 8'h00;
      data_reg      <= 8'h00;
      tmo_reg       <= 16'h0000;
      busy_reg      <= 1'b0;
      wr_valid_reg  <= 1'b0;
      wr_addr_reg   <= 4'h0;
      wr_data_reg   <= 8'h00;
      err_reg       <= 1'b0;
      err_code_reg  <= 2'b00;
      err_count_reg <= 8'h00;
    end else begin
      wr_valid_reg <= wr_fire;
      err_reg      <= err_fire;
      if (wr_fire) begin
        wr_addr_reg <= addr_reg[3:0];
        wr_data_reg <= data_reg;
      end
      if (err_fire) begin
        err_code_reg <= err_code_next;
        if (err_count_reg != 8'hFF)
          err_count_reg <= err_count_reg + 8'h01;
      end

      if (in_frame && !bus.rx_dv) begin
        if (tmo_hit) begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
          tmo_reg   <= 16'h0000;
        end else begin
          tmo_reg <= tmo_reg + 16'h0001;
        end
      end

      if (bus.rx_dv) begin
        tmo_reg <= 16'h0000;
        case (state_reg)
          IDLE: begin
            if (bus.rx_byte == SYNC_BYTE) begin
              state_reg <= GET_ADDR;
              busy_reg  <= 1'b1;
            end
          end
          GET_ADDR: begin
            addr_reg  <= bus.rx_byte;
            state_reg <= GET_DATA;
          end
          GET_DATA: begin
            data_reg  <= bus.rx_byte;
            state_reg <= GET_CHK;
          end
          GET_CHK: begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end
          default: begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      for (int i = 0; i < NUM_REGS; i++)
        regs_reg[i] <= 8'h00;
    end else begin
      for (int i = 0; i < NUM_REGS; i++)
        if (wr_fire && (addr_reg == 8'(i)))
          regs_reg[i] <= data_reg;
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_flat
      assign regs_flat[8*gi +: 8] = regs_reg[gi];
    end
  endgenerate

  assign bus.regs      = regs_flat;
  assign bus.wr_valid  = wr_valid_reg;
  assign bus.wr_addr   = wr_addr_reg;
  assign bus.wr_data   = wr_data_reg;
  assign bus.err       = err_reg;
  assign bus.err_code  = err_code_reg;
  assign bus.err_count = err_count_reg;
  assign bus.busy      = busy_reg;

endmodule

// File: tb/tb_uart_rx_reg_ctrl.sv
// Randomized and directed frame stimulus for uart_rx_reg_ctrl, checked every cycle against
// a frame-level model that collects bytes in a queue and judges whole frames.
module tb_uart_rx_reg_ctrl;
  localparam int         NREGS = 4;
  localparam logic [7:0] SYNC  = 8'hA5;
  localparam int         TMO   = 40;

  logic i_Clock = 1'b0;
  logic i_Rst_L = 1'b0;

  uart_rx_reg_ctrl_if #(.NUM_REGS(NREGS)) bus ();

  uart_rx_reg_ctrl #(
    .NUM_REGS     (NREGS),
    .SYNC_BYTE    (SYNC),
    .TIMEOUT_CLKS (TMO)
  ) dut (
    .i_Clock (i_Clock),
    .i_Rst_L (i_Rst_L),
    .bus     (bus)
  );

  always #5 i_Clock = ~i_Clock;

  int vec_cnt = 0;
  int miscompare_cnt = 0;

  // Frame-level reference model
  logic [7:0] m_regs [NREGS];
  logic [7:0] m_frame [$];
  int         m_gap;
  logic       e_wr_valid;
  logic [3:0] e_wr_addr;
  logic [7:0] e_wr_data;
  logic       e_err;
  logic [1:0] e_code;
  int         e_cnt;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miscompare_cnt++;
      $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NREGS; i++) m_regs[i] = 8'h00;
    m_frame.delete();
    m_gap = 0;
    e_wr_valid = 1'b0; e_wr_addr = 4'h0; e_wr_data = 8'h00;
    e_err = 1'b0; e_code = 2'b00; e_cnt = 0;
  endtask

  task automatic raise(input logic [1:0] code);
    e_err  = 1'b1;
    e_code = code;
    if (e_cnt < 255) e_cnt++;
  endtask

  task automatic model_step(input logic dv, input logic [7:0] b);
    logic [7:0] a, d, c;
    e_wr_valid = 1'b0;
    e_err      = 1'b0;
    if (dv) begin
      if (m_frame.size() != 0 || b == SYNC) m_frame.push_back(b);
      m_gap = 0;
      if (m_frame.size() == 4) begin
        a = m_frame[1]; d = m_frame[2]; c = m_frame[3];
        if (c != (a ^ d))           raise(2'b01);
        else if (int'(a) >= NREGS)  raise(2'b10);
        else begin
          m_regs[a] = d;
          e_wr_valid = 1'b1; e_wr_addr = a[3:0]; e_wr_data = d;
        end
        m_frame.delete();
      end
    end else if (m_frame.size() != 0) begin
      m_gap++;
      if (m_gap == TMO) begin
        raise(2'b11);
        m_frame.delete();
      end
    end
  endtask

  task automatic check_all();
    logic [31:0] flat;
    flat = '0;
    for (int i = 0; i < NREGS; i++) flat[8*i +: 8] = m_regs[i];
    check_val("regs",      bus.regs,      flat);
    check_val("wr_valid",  32'(bus.wr_valid),  32'(e_wr_valid));
    check_val("wr_addr",   32'(bus.wr_addr),   32'(e_wr_addr));
    check_val("wr_data",   32'(bus.wr_data),   32'(e_wr_data));
    check_val("err",       32'(bus.err),       32'(e_err));
    check_val("err_code",  32'(bus.err_code),  32'(e_code));
    check_val("err_count", 32'(bus.err_count), 32'(e_cnt));
    check_val("busy",      32'(bus.busy),      32'(m_frame.size() != 0));
  endtask

  task automatic step(input logic dv, input logic [7:0] b);
    bus.rx_dv   = dv;
    bus.rx_byte = dv ? b : 8'($urandom);
    @(posedge i_Clock); #1;
    model_step(dv, b);
    check_all();
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    for (int i = 0; i < gap; i++) step(1'b0, 8'h00);
    step(1'b1, b);
  endtask

  task automatic frame(input logic [7:0] a, input logic [7:0] d, input logic [7:0] c, input int gap);
    send(SYNC, gap); send(a, gap); send(d, gap); send(c, gap);
    $display("frame %02h %02h %02h %02h -> wr_valid=%0b err=%0b code=%0d cnt=%0d regs=%h",
             SYNC, a, d, c, bus.wr_valid, bus.err, bus.err_code, bus.err_count, bus.regs);
  endtask

  task automatic do_reset();
    i_Rst_L     = 1'b0;
    bus.rx_dv   = 1'b0;
    bus.rx_byte = 8'h00;
    #2;
    model_reset();
    check_all();
    @(posedge i_Clock); #1;
    check_all();
    i_Rst_L = 1'b1;
    $display("reset applied: regs=%h cnt=%0d busy=%0b", bus.regs, bus.err_count, bus.busy);
  endtask

  initial begin
    bus.rx_dv   = 1'b0;
    bus.rx_byte = 8'h00;
    do_reset();
    step(1'b0, 8'h00);

    // 1: good write
    frame(8'h02, 8'h3C, 8'h3E, 2);
    check_val("t1_regs", bus.regs, 32'h003C_0000);
    check_val("t1_wrv",  32'(bus.wr_valid), 32'd1);
    step(1'b0, 8'h00);
    check_val("t1_pulse_end", 32'(bus.wr_valid), 32'd0);

    // 2: bad checksum
    frame(8'h01, 8'h55, 8'h00, 1);
    check_val("t2_code", 32'(bus.err_code), 32'd1);
    check_val("t2_cnt",  32'(bus.err_count), 32'd1);

    // 3: address out of range, then a good write to reg0
    frame(8'h07, 8'h11, 8'h16, 0);
    check_val("t3_code", 32'(bus.err_code), 32'd2);
    frame(8'h00, 8'hFF, 8'hFF, 3);
    check_val("t3_regs", bus.regs, 32'h003C_00FF);

    // 4: timeout exactly at expiry, then DV on the expiry cycle
    send(SYNC, 1); send(8'h03, 1);
    for (int i = 0; i < TMO - 1; i++) step(1'b0, 8'h00);
    check_val("t4_pre_err", 32'(bus.err), 32'd0);
    step(1'b0, 8'h00);
    check_val("t4_err",  32'(bus.err), 32'd1);
    check_val("t4_code", 32'(bus.err_code), 32'd3);
    check_val("t4_busy", 32'(bus.busy), 32'd0);
    $display("timeout: err=%0b code=%0d cnt=%0d", bus.err, bus.err_code, bus.err_count);
    send(SYNC, 1); send(8'h03, 1); send(8'h20, TMO - 1);
    check_val("t4_no_err", 32'(bus.err), 32'd0);
    send(8'h23, 2);
    check_val("t4_wr", bus.regs, 32'h203C_00FF);

    // 5: junk ignored, sync byte as data
    send(8'h00, 1); send(8'hFF, 0); send(8'h12, 0);
    check_val("t5_busy", 32'(bus.busy), 32'd0);
    frame(8'h01, SYNC, 8'hA4, 1);
    check_val("t5_regs", bus.regs, 32'h203C_A5FF);

    // 6: error count saturation with back-to-back DV
    for (int i = 0; i < 260; i++) begin
      send(SYNC, 0); send(8'h01, 0); send(8'h00, 0); send(8'h00, 0);
    end
    check_val("t6_sat", 32'(bus.err_count), 32'd255);
    $display("saturation: cnt=%0d", bus.err_count);

    // Reset mid-frame, then a good frame
    send(SYNC, 1); send(8'h01, 1);
    do_reset();
    check_val("rst_regs", bus.regs, 32'h0);
    check_val("rst_cnt",  32'(bus.err_count), 32'd0);
    frame(8'h02, 8'h3C, 8'h3E, 1);
    check_val("rst_wr", bus.regs, 32'h003C_0000);

    // Random frames with occasional junk, long gaps and bad checksums
    for (int f = 0; f < 300; f++) begin
      logic [7:0] a, d, c;
      int junk;
      int g [4];
      junk = $urandom_range(0, 2);
      for (int j = 0; j < junk; j++) send(8'($urandom), $urandom_range(0, 3));
      for (int k = 0; k < 4; k++)
        g[k] = ($urandom_range(0, 9) == 0) ? $urandom_range(TMO - 2, TMO + 2) : $urandom_range(0, 6);
      a = 8'($urandom_range(0, 5));
      d = 8'($urandom);
      c = ($urandom_range(0, 3) != 0) ? (a ^ d) : 8'($urandom);
      send(SYNC, g[0]); send(a, g[1]); send(d, g[2]); send(c, g[3]);
      $display("rand frame %0d: %02h %02h %02h gaps %0d/%0d/%0d -> wr=%0b err=%0b code=%0d",
               f, a, d, c, g[1], g[2], g[3], bus.wr_valid, bus.err, bus.err_code);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompare_cnt);
    $finish;
  end
endmodule
